ides4_align_ctrl: RTL and testbench

IDES4_ALIGN_CTRL -- requirements
Module: ides4_align_ctrl

---
 rtl/ides4_align_ctrl.sv | 175 +++++++++++++++++
 tb/tb_ides4_align_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ides4_align_ctrl.sv
// ides4_align_ctrl: word-alignment controller for an IDES4 deserializer.
// It checks the parallel word against a training nibble and pulses calib to
// slip the word boundary until LOCK_COUNT consecutive matches are seen.
// Once locked, it can optionally count IEM drift events while holding lock.
//
// Optional feature macro: IDES4_ALIGN_IEM_MON_EN
//   defined   : drift_cnt counts lead|lag cycles while LOCKED, saturating at 255
//   undefined : lead/lag are ignored and drift_cnt is constant 0
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for en; counters hold their last values
// S_CHECK  | comparing q against PATTERN and counting consecutive matches
// S_SLIP   | one-cycle calib pulse to the IDES4
// S_WAIT   | CALIB_GAP cycles of settling; q ignored
// S_LOCKED | alignment achieved; payload traffic not checked
// S_FAIL   | MAX_SLIPS exhausted; alignment abandoned until en drops

module ides4_align_ctrl #(
    parameter logic [3:0] PATTERN    = 4'b0011,
    parameter int         LOCK_COUNT = 16,
    parameter int         CALIB_GAP  = 4,
    parameter int         MAX_SLIPS  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] q,
    input  logic       lead,
    input  logic       lag,
    output logic       calib,
    output logic       busy,
    output logic       locked,
    output logic       fail,
    output logic [3:0] slip_cnt,
    output logic [7:0] drift_cnt
);

    localparam logic [7:0] LOCK_CNT8  = 8'(LOCK_COUNT);
    localparam logic [3:0] MAX_SLIPS4 = 4'(MAX_SLIPS);
    localparam logic [3:0] GAP_LOAD   = 4'(CALIB_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_SLIP   = 3'd2,
        S_WAIT   = 3'd3,
        S_LOCKED = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] match_cnt_q, match_cnt_d;
    logic [3:0] slip_cnt_q, slip_cnt_d;
    logic [7:0] drift_cnt_q, drift_cnt_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       calib_q, busy_q, locked_q, fail_q;

`ifdef IDES4_ALIGN_IEM_MON_EN
    logic drift_evt;
    assign drift_evt = lead | lag;
`else
    logic unused_iem;
    assign unused_iem = lead ^ lag;
`endif

    // Next-state and counter update logic.
    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        slip_cnt_d  = slip_cnt_q;
        drift_cnt_d = drift_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d     = S_CHECK;
                    match_cnt_d = 8'd0;
                    slip_cnt_d  = 4'd0;
                    drift_cnt_d = 8'd0;
                end
            end
            S_CHECK: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (q == PATTERN) begin
                    match_cnt_d = match_cnt_q + 8'd1;
                    if (match_cnt_q + 8'd1 == LOCK_CNT8) begin
                        state_d = S_LOCKED;
                    end
                end else begin
                    match_cnt_d = 8'd0;
                    if (slip_cnt_q < MAX_SLIPS4) begin
                        // count the slip on entry so slip_cnt is current during the pulse
                        state_d    = S_SLIP;
                        slip_cnt_d = slip_cnt_q + 4'd1;
                    end else begin
                        state_d = S_FAIL;
                    end
                end
            end
            S_SLIP: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else begin
                    state_d    = S_WAIT;
                    wait_cnt_d = GAP_LOAD;
                end
            end
            S_WAIT: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (wait_cnt_q == 4'd0) begin
                    state_d     = S_CHECK;
                    match_cnt_d = 8'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_LOCKED: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else begin
`ifdef IDES4_ALIGN_IEM_MON_EN
                    if (drift_evt && (drift_cnt_q != 8'hFF)) begin
                        drift_cnt_d = drift_cnt_q + 8'd1;
                    end
`endif
                end
            end
            S_FAIL: begin
                if (!en) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and outputs; outputs are registered from the next state
    // so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            match_cnt_q <= 8'd0;
            slip_cnt_q  <= 4'd0;
            drift_cnt_q <= 8'd0;
            wait_cnt_q  <= 4'd0;
            calib_q     <= 1'b0;
            busy_q      <= 1'b0;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            slip_cnt_q  <= slip_cnt_d;
            drift_cnt_q <= drift_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            calib_q     <= (state_d == S_SLIP);
            busy_q      <= (state_d == S_CHECK) || (state_d == S_SLIP) || (state_d == S_WAIT);
            locked_q    <= (state_d == S_LOCKED);
            fail_q      <= (state_d == S_FAIL);
        end
    end

    assign calib     = calib_q;
    assign busy      = busy_q;
    assign locked    = locked_q;
    assign fail      = fail_q;
    assign slip_cnt  = slip_cnt_q;
    assign drift_cnt = drift_cnt_q;

endmodule

// File: tb/tb_ides4_align_ctrl.sv
// tb_ides4_align_ctrl: directed bench for ides4_align_ctrl with default
// parameters (PATTERN=0011, LOCK_COUNT=16, CALIB_GAP=4, MAX_SLIPS=8).
// Outputs are sampled 1 time unit after each rising edge; inputs change there too.
// Drift expectations follow IDES4_ALIGN_IEM_MON_EN.

module tb_ides4_align_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] q = 4'b0000;
    logic       lead = 1'b0;
    logic       lag = 1'b0;
    logic       calib, busy, locked, fail;
    logic [3:0] slip_cnt;
    logic [7:0] drift_cnt;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int calib_cnt = 0;
    int calib_wide = 0;
    int prev_pulse = 0;
    int last_pulse = 0;
    logic calib_prev = 1'b0;

`ifdef IDES4_ALIGN_IEM_MON_EN
    localparam int DRIFT_SAT = 255;
    localparam int DRIFT_ONE = 1;
`else
    localparam int DRIFT_SAT = 0;
    localparam int DRIFT_ONE = 0;
`endif

    ides4_align_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .q         (q),
        .lead      (lead),
        .lag       (lag),
        .calib     (calib),
        .busy      (busy),
        .locked    (locked),
        .fail      (fail),
        .slip_cnt  (slip_cnt),
        .drift_cnt (drift_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // advance one clock and track calib pulses
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (calib) begin
            calib_cnt++;
            if (calib_prev) calib_wide++;
            prev_pulse = last_pulse;
            last_pulse = cyc;
        end
        calib_prev = calib;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        q   = 4'b0000;
        lead = 1'b0;
        lag  = 1'b0;
        step();
        step();
        rst = 1'b0;
        calib_cnt  = 0;
        calib_wide = 0;
    endtask

    task automatic wait_locked(input int bound, output int n);
        n = 0;
        while (!locked && n < bound) begin
            step();
            n++;
        end
    endtask

    task automatic wait_fail(input int bound, output int n);
        n = 0;
        while (!fail && n < bound) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;

        // reset with en high: reset wins
        rst = 1'b1;
        en  = 1'b1;
        step();
        step();
        chk("rst_calib", 32'(calib), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_fail", 32'(fail), 0);
        chk("rst_slip", 32'(slip_cnt), 0);
        chk("rst_drift", 32'(drift_cnt), 0);

        // clean training pattern: 1 IDLE edge + 16 CHECK edges, lock in the 18th cycle
        do_reset();
        en = 1'b1;
        q  = 4'b0011;
        step();
        chk("clean_busy", 32'(busy), 1);
        wait_locked(40, n);
        chk("clean_lock_edges", 32'(n + 1), 17);
        chk("clean_calib", 32'(calib_cnt), 0);
        chk("clean_slip", 32'(slip_cnt), 0);
        chk("clean_busy_lk", 32'(busy), 0);
        // q ignored while locked
        q = 4'b0000;
        step();
        step();
        chk("lock_hold", 32'(locked), 1);
        en = 1'b0;
        step();
        chk("lock_drop", 32'(locked), 0);

        // two slips then lock
        do_reset();
        en = 1'b1;
        q  = 4'b1001;
        n  = 0;
        while (calib_cnt < 2 && n < 100) begin
            step();
            n++;
        end
        q = 4'b0011;
        chk("two_pulse_cnt", 32'(calib_cnt), 2);
        chk("two_pulse_gap", 32'(last_pulse - prev_pulse), 6);
        wait_locked(60, n);
        chk("two_lock_edges", 32'(n), 21);
        chk("two_slip", 32'(slip_cnt), 2);
        chk("two_wide", 32'(calib_wide), 0);
        chk("two_calib_tot", 32'(calib_cnt), 2);

        // persistent mismatch: 8 slips then fail
        do_reset();
        en = 1'b1;
        q  = 4'b0000;
        wait_fail(200, n);
        chk("fail_flag", 32'(fail), 1);
        chk("fail_busy", 32'(busy), 0);
        chk("fail_pulses", 32'(calib_cnt), 8);
        chk("fail_slip", 32'(slip_cnt), 8);
        chk("fail_wide", 32'(calib_wide), 0);
        for (int i = 0; i < 10; i++) step();
        chk("fail_hold", 32'(fail), 1);
        chk("fail_pulses_hold", 32'(calib_cnt), 8);

        // 15 matches, 1 mismatch, mismatches ignored through SLIP/WAIT, then matches
        do_reset();
        en = 1'b1;
        q  = 4'b0011;
        step();
        for (int i = 0; i < 15; i++) step();
        chk("m15_not_locked", 32'(locked), 0);
        q = 4'b0000;
        step();
        chk("m15_calib", 32'(calib), 1);
        for (int i = 0; i < 4; i++) step();
        q = 4'b0011;
        step();
        wait_locked(40, n);
        chk("m15_relock_edges", 32'(n + 5), 21);
        chk("m15_pulses", 32'(calib_cnt), 1);
        chk("m15_slip", 32'(slip_cnt), 1);

        // en dropped in WAIT: IDLE next cycle, slip_cnt holds, restarts on IDLE exit
        do_reset();
        en = 1'b1;
        q  = 4'b0000;
        step();
        step();
        chk("ew_slip_calib", 32'(calib), 1);
        step();
        chk("ew_in_wait", 32'(busy), 1);
        en = 1'b0;
        step();
        chk("ew_busy", 32'(busy), 0);
        chk("ew_calib", 32'(calib), 0);
        chk("ew_slip_hold", 32'(slip_cnt), 1);
        step();
        step();
        chk("ew_slip_hold2", 32'(slip_cnt), 1);
        en = 1'b1;
        q  = 4'b0011;
        step();
        chk("ew_slip_restart", 32'(slip_cnt), 0);

        // rst during SLIP
        q = 4'b0000;
        step();
        chk("rs_in_slip", 32'(calib), 1);
        rst = 1'b1;
        step();
        chk("rs_calib", 32'(calib), 0);
        chk("rs_busy", 32'(busy), 0);
        chk("rs_slip", 32'(slip_cnt), 0);
        rst = 1'b0;
        step();
        chk("rs_restart_busy", 32'(busy), 1);
        chk("rs_restart_slip", 32'(slip_cnt), 0);

        // IEM drift monitor
        do_reset();
        en = 1'b1;
        q  = 4'b0011;
        wait_locked(40, n);
        chk("dr_locked", 32'(locked), 1);
        lag = 1'b1;
        for (int i = 0; i < 300; i++) step();
        lag = 1'b0;
        step();
        chk("dr_sat", 32'(drift_cnt), 32'(DRIFT_SAT));
        en = 1'b0;
        step();
        chk("dr_hold_idle", 32'(drift_cnt), 32'(DRIFT_SAT));
        en = 1'b1;
        wait_locked(40, n);
        chk("dr_clear", 32'(drift_cnt), 0);
        lead = 1'b1;
        lag  = 1'b1;
        step();
        lead = 1'b0;
        lag  = 1'b0;
        step();
        step();
        chk("dr_both_one", 32'(drift_cnt), 32'(DRIFT_ONE));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
